vga_pattern_gen: RTL

//  Parametrised VGA timing + test-pattern generator; successor to the fixed 640x480 solid-colour test.

---
 rtl/vga_if.sv | 38 +++
 rtl/vga_pattern_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_if.sv
// ---------------------------------------------------------------------------
// vga_if
//   Bundles the pixel-enable, pattern controls and video outputs of the
//   pattern generator.
//   master : the generator side (takes pix_en/mode/color_sel, drives video)
//   slave  : the consumer/driver side (drives controls, receives video)
//   Signals
//     pix_en      pixel strobe
//     mode        pattern select (frame-latched inside the generator)
//     color_sel   {r,g,b} colour enables, used live
//     hsync_out   horizontal sync
//     vsync_out   vertical sync
//     de          display enable
//     pixel       {R,G,B}, CW bits per channel
//     frame_start one-clock pulse with the outputs of pixel (0,0)
// ---------------------------------------------------------------------------
interface vga_if #(
    parameter int CW = 1
);
    logic              pix_en;
    logic [2:0]        mode;
    logic [2:0]        color_sel;
    logic              hsync_out;
    logic              vsync_out;
    logic              de;
    logic [3*CW-1:0]   pixel;
    logic              frame_start;

    modport master (
        input  pix_en, mode, color_sel,
        output hsync_out, vsync_out, de, pixel, frame_start
    );

    modport slave (
        output pix_en, mode, color_sel,
        input  hsync_out, vsync_out, de, pixel, frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//   Parametrised VGA timing and test-pattern generator running on the system
//   clock, advanced by a pixel-enable strobe. Sync, DE, RGB and frame_start
//   are registered on the same enable and stay mutually aligned, one enable
//   behind the internal (h,v) counters.
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset; restarts at (0,0)
//     vif    vga_if.master: pix_en, mode, color_sel in;
//            hsync_out, vsync_out, de, pixel, frame_start out
//   Patterns (frame-latched mode): 0 solid, 1 colour bars, 2 checker,
//   3 grey ramp, 4 border, 5 moving bar, 6/7 black.
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    vga_if.master  vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] BAR_W_LAST = XW'(BAR_W - 1);
    localparam logic [XW-1:0] BAR_MAX    = XW'(H_ACTIVE - 16);

    // Decode comparisons use one extra bit so a sync window that ends exactly
    // at the line/frame total still fits.
    localparam logic [XW:0] H_ACT_E    = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] H_ACT_LAST = (XW+1)'(H_ACTIVE - 1);
    localparam logic [XW:0] HS_BEG     = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] HS_END     = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW:0] BAR_LEN    = (XW+1)'(16);
    localparam logic [YW:0] V_ACT_E    = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] V_ACT_LAST = (YW+1)'(V_ACTIVE - 1);
    localparam logic [YW:0] VS_BEG     = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] VS_END     = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

    // A 1-bit channel value fills every bit of that channel.
    function automatic logic [CW-1:0] expand(input logic bit_in);
        return {CW{bit_in}};
    endfunction

    logic [XW-1:0]   h_cnt_p0;
    logic [YW-1:0]   v_cnt_p0;
    logic [2:0]      mode_q;
    logic [XW-1:0]   bar_pos;
    logic [XW-1:0]   bar_cnt;
    logic [2:0]      bar_idx;

    logic            hsync_p1;
    logic            vsync_p1;
    logic            de_p1;
    logic            frame_start_p1;
    logic [3*CW-1:0] pixel_p1;

    logic [XW:0]     h_e;
    logic [YW:0]     v_e;
    logic            active;
    logic            hs;
    logic            vs;
    logic            h_end;
    logic            v_end;
    logic            h_b5;
    logic            v_b5;
    logic            border;
    logic            in_bar;
    logic [CW-1:0]   grey;
    logic [2:0]      ch;
    logic            grey_sel;
    logic [3*CW-1:0] pix_next;

    // ---- stage p0: position decode from the current counters ----
    assign h_e    = {1'b0, h_cnt_p0};
    assign v_e    = {1'b0, v_cnt_p0};
    assign active = (h_e < H_ACT_E) && (v_e < V_ACT_E);
    assign hs     = (h_e >= HS_BEG) && (h_e < HS_END);
    assign vs     = (v_e >= VS_BEG) && (v_e < VS_END);
    assign h_end  = (h_cnt_p0 == H_LAST);
    assign v_end  = (v_cnt_p0 == V_LAST);
    assign border = (h_cnt_p0 == '0) || (h_e == H_ACT_LAST) ||
                    (v_cnt_p0 == '0) || (v_e == V_ACT_LAST);
    assign in_bar = (h_e >= {1'b0, bar_pos}) && (h_e < ({1'b0, bar_pos} + BAR_LEN));

    // Checker cell bit 5; counters narrower than 6 bits never leave cell 0.
    if (XW > 5) begin : g_hb5
        assign h_b5 = h_cnt_p0[5];
    end else begin : g_hb5_zero
        assign h_b5 = 1'b0;
    end
    if (YW > 5) begin : g_vb5
        assign v_b5 = v_cnt_p0[5];
    end else begin : g_vb5_zero
        assign v_b5 = 1'b0;
    end

    // Grey level is the top CW bits of h, i.e. h >> (XW-CW).
    if (XW >= CW) begin : g_grey
        assign grey = h_cnt_p0[XW-1 -: CW];
    end else begin : g_grey_wide
        assign grey = CW'(h_cnt_p0);
    end

    always_comb begin
        ch       = 3'b000;
        grey_sel = 1'b0;
        pix_next = '0;
        case (mode_q)
            3'd0:    ch = vif.color_sel;
            3'd1:    ch = ~bar_idx;               // 7-k: bar 0 white, bar 7 black
            3'd2:    ch = (h_b5 ^ v_b5) ? vif.color_sel : 3'b000;
            3'd3:    grey_sel = 1'b1;
            3'd4:    ch = border ? 3'b111 : 3'b000;
            3'd5:    ch = in_bar ? 3'b111 : 3'b000;
            default: ch = 3'b000;
        endcase
        if (active) begin
            if (grey_sel) begin
                pix_next = {grey, grey, grey};
            end else begin
                pix_next = {expand(ch[2]), expand(ch[1]), expand(ch[0])};
            end
        end
    end

    // ---- stage p1: registered outputs, counters advance ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_p0       <= '0;
            v_cnt_p0       <= '0;
            mode_q         <= 3'd0;
            bar_pos        <= '0;
            bar_cnt        <= '0;
            bar_idx        <= 3'd0;
            hsync_p1       <= ~HS_POL;
            vsync_p1       <= ~VS_POL;
            de_p1          <= 1'b0;
            frame_start_p1 <= 1'b0;
            pixel_p1       <= '0;
        end else begin
            // Single-clock pulse: cleared on any clock that is not registering (0,0).
            frame_start_p1 <= vif.pix_en && (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
            if (vif.pix_en) begin
                hsync_p1 <= hs ? HS_POL : ~HS_POL;
                vsync_p1 <= vs ? VS_POL : ~VS_POL;
                de_p1    <= active;
                pixel_p1 <= pix_next;
                if (h_end) begin
                    h_cnt_p0 <= '0;
                    bar_cnt  <= '0;
                    bar_idx  <= 3'd0;
                    v_cnt_p0 <= v_end ? '0 : v_cnt_p0 + 1'b1;
                end else begin
                    h_cnt_p0 <= h_cnt_p0 + 1'b1;
                    // Bar index tracks h / BAR_W without a divider.
                    if (bar_cnt == BAR_W_LAST) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 1'b1;
                    end else begin
                        bar_cnt <= bar_cnt + 1'b1;
                    end
                end
                if (h_end && v_end) begin
                    mode_q  <= vif.mode;
                    bar_pos <= (bar_pos == BAR_MAX) ? '0 : bar_pos + 1'b1;
                end
            end
        end
    end

    assign vif.hsync_out   = hsync_p1;
    assign vif.vsync_out   = vsync_p1;
    assign vif.de          = de_p1;
    assign vif.pixel       = pixel_p1;
    assign vif.frame_start = frame_start_p1;

endmodule
